mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one pipelined array multiplier (sub-module `multiplier`, parameter `width`, latency WIDTH+1 clocks, no stall) among NUM_REQ requesters.
- Arbitration is round-robin, one issue per clock.
- An operation tag travels alongside the multiplier pipeline, so each product returns with the ID of the requester that issued it.
- Also provides a drain sequence so upstream logic can quiesce the multiplier, e.g. before reconfiguration or sampling.

Parameters:
- WIDTH, 4, operand width; passed to `multiplier` as `width`.
- NUM_REQ, 3, number of requesters; must be at least 2.
- ID_W, $clog2(NUM_REQ), width of the requester-ID field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand b; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and state
- drain_req  in  1  level request: stop granting and empty the pipeline
- drain_done  out  1  one-cycle pulse when the drain completes
- res_valid  out  1  a product is present on res_y
- res_id  out  ID_W  requester that issued the product
- res_y  out  2*WIDTH  product
- busy  out  1  at least one operation is in flight

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - res_valid=0, res_id=0, drain_done=0, busy=0.
  - Tag pipeline valid bits all 0; in-flight counter 0; state=RUN; round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: every in-flight tag is discarded and no res_valid fires for it. Multiplier data registers are not reset and their contents are don't-care.
- Handshake:
  - A transfer happens when req_valid[i] && req_ready[i].
  - At most one req_ready bit is high per cycle, and req_ready[i] implies req_valid[i].
  - Unselected operands are ignored.
  - The granted requester's a/b are driven into the multiplier inputs in the same cycle.
- Round-robin:
  - The search starts at pointer+1 and wraps modulo NUM_REQ.
  - The pointer updates to the granted index only when a grant occurs; otherwise it holds.
- Tag pipeline:
  - A shift register of depth LAT=WIDTH+1 carrying {valid, id}, advancing every clock.
  - Stage 0 is loaded with {grant_fired, grant_id}.
  - res_valid/res_id come from the last stage and are aligned with the multiplier output y, which feeds res_y directly.
  - A product granted at edge k appears at edge k+LAT.
  - With no transfer, the stage-0 valid bit is 0.
- In-flight counter:
  - Range 0..LAT, inclusive.
  - Increments on a grant and decrements on res_valid; both in the same cycle leaves it unchanged.
  - busy = (count != 0).
- State machine:
  - RUN: normal grants. drain_req=1 → DRAIN.
  - DRAIN: req_ready forced to 0. When count==0 (counter value at that edge) → IDLE, with drain_done pulsed for 1 cycle in the first IDLE cycle. If count is already 0 on entry, the transition to IDLE happens on the next edge.
  - IDLE: req_ready forced to 0. drain_req=0 → RUN.
  - drain_req falling while in DRAIN: stay in DRAIN until empty, then go to IDLE. IDLE is then left on the following edge because drain_req=0.
- Throughput: 1 product per clock with no bubbles; no backpressure on results, so the consumer must accept every res_valid.
- Arithmetic: the product is unsigned and full width (2*WIDTH); no truncation.

Optional Feature:
- Macro: MULT_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_grants (NUM_REQ*16): a per-requester saturating grant counter, cleared by rst, that holds at 16'hFFFF.
  - Adds output stat_idle (16): a saturating count of RUN cycles with no grant.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Shared package mult_pkg holds:
  - typedef state_t {RUN, DRAIN, IDLE};
  - function mult_latency(width) returning width+1;
  - typedef tag_t {valid, id} for the tag pipeline.
- Natural sub-module: mult_rr_arbiter (round-robin grant plus pointer).
- `multiplier` is instantiated unchanged.

Test Plan:
All cases use WIDTH=4, NUM_REQ=3, LAT=5.
- Single request: req 1 presents a=7, b=9 for one cycle → req_ready=3'b010; res_valid with res_id=1 and res_y=63 exactly 5 cycles later; busy high for 5 cycles.
- All three valid for 6 cycles with a=i+1, b=3 → grant order 0,1,2,0,1,2; results 3,6,9,3,6,9 on consecutive cycles with matching ids.
- Operand extremes: a=15, b=15 → res_y=225; a=0, b=15 → res_y=0.
- Drain: assert drain_req after 3 back-to-back grants → req_ready=0 from that cycle; the 3 results still return; drain_done pulses once after count reaches 0. Drain when already empty → IDLE and drain_done on the next edge.
- Reset mid-flight: rst for 1 cycle with 4 operations in flight → no res_valid afterwards; busy=0; the next grant goes to requester 0.
- Pointer hold: req 2 alone, then reqs 0 and 2 together → grant 2, then 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mult_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  // Tag id field is sized for the largest supported requester count;
  // instances use the low ID_W bits.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int mult_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin grant among NUM_REQ requesters. The search starts one past
// the last granted index; the pointer only moves when a grant fires.
module mult_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_fired
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_cand;
  logic [ID_W-1:0]    w_cand_id;
  logic               w_any;

  function automatic int wrap_idx(input int p, input int off);
    return (p + off) % NUM_REQ;
  endfunction

  // First valid requester after the pointer, wrapping.
  always_comb begin
    w_cand    = '0;
    w_cand_id = '0;
    w_any     = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!w_any && i_req_valid[wrap_idx(int'(r_ptr), off)]) begin
        w_any = 1'b1;
        w_cand[wrap_idx(int'(r_ptr), off)] = 1'b1;
        w_cand_id = ID_W'(wrap_idx(int'(r_ptr), off));
      end
    end
  end

  assign o_fired    = i_en && w_any;
  assign o_grant    = i_en ? w_cand : '0;
  assign o_grant_id = w_cand_id;

  // Pointer follows the granted index; reset value gives requester 0 first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (o_fired) begin
      r_ptr <= w_cand_id;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Pipelined unsigned shift-add array multiplier, latency width+1, no stall.
// Data registers are deliberately not reset.
module multiplier #(
  parameter int width = 4
) (
  input  logic               clk,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] y
);

  logic [width-1:0]   r_a   [width];
  logic [width-1:0]   r_b   [width];
  logic [2*width-1:0] r_acc [width+1];

  // Input capture then one partial product accumulated per stage.
  always_ff @(posedge clk) begin
    r_a[0]   <= a;
    r_b[0]   <= b;
    r_acc[0] <= '0;
    for (int j = 1; j < width; j++) begin
      r_a[j] <= r_a[j-1];
      r_b[j] <= r_b[j-1];
    end
    for (int j = 1; j <= width; j++) begin
      r_acc[j] <= r_acc[j-1] +
                  (r_b[j-1][j-1] ? ({{width{1'b0}}, r_a[j-1]} << (j-1)) : '0);
    end
  end

  assign y = r_acc[width];

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin
// issue, a tag pipeline returning the issuing requester id with each product,
// and a drain sequence to quiesce the pipeline.
// Optional statistics outputs: define MULT_SHARE_ARBITER_STATS_EN.
//
// state | meaning
// RUN   | normal round-robin grants
// DRAIN | grants blocked, waiting for in-flight ops to return
// IDLE  | pipeline empty, grants blocked until drain_req drops
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [2*WIDTH-1:0]       res_y,
  output logic                     busy
`ifdef MULT_SHARE_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    stat_grants,
  output logic [15:0]              stat_idle
`endif
);

  localparam int LAT   = mult_latency(WIDTH);
  localparam int CNT_W = $clog2(LAT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_grant_en;
  logic               w_drain_fin;
  logic               w_fired;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [WIDTH-1:0]   w_mul_a;
  logic [WIDTH-1:0]   w_mul_b;
  logic [2*WIDTH-1:0] w_mul_y;
  tag_t               r_tag [LAT];
  logic [CNT_W-1:0]   r_count;
  logic               r_drain_done;
  logic               w_unused_id;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant enable; drain_req blocks grants in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_drain_fin = 1'b0;
    unique case (r_state)
      RUN: begin
        if (drain_req) begin
          w_state_nxt = DRAIN;
        end else begin
          w_grant_en = 1'b1;
        end
      end
      DRAIN: begin
        if (r_count == '0) begin
          w_state_nxt = IDLE;
          w_drain_fin = 1'b1;
        end
      end
      IDLE: begin
        if (!drain_req) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_en        (w_grant_en),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id),
    .o_fired     (w_fired)
  );

  assign req_ready = w_grant;

  // Granted requester's operands go straight into the multiplier.
  always_comb begin
    w_mul_a = req_a[int'(w_grant_id)*WIDTH +: WIDTH];
    w_mul_b = req_b[int'(w_grant_id)*WIDTH +: WIDTH];
  end

  multiplier #(
    .width (WIDTH)
  ) u_mult (
    .clk (clk),
    .a   (w_mul_a),
    .b   (w_mul_b),
    .y   (w_mul_y)
  );

  // Tag pipeline runs in lockstep with the multiplier stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0].valid <= w_fired;
      r_tag[0].id    <= TAG_ID_W'(w_grant_id);
      for (int i = 1; i < LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign res_valid   = r_tag[LAT-1].valid;
  assign res_id      = r_tag[LAT-1].id[ID_W-1:0];
  assign res_y       = w_mul_y;
  assign w_unused_id = ^r_tag[LAT-1].id;

  // In-flight counter: +1 on issue, -1 on result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_fired && !res_valid) begin
      r_count <= r_count + 1'b1;
    end else if (!w_fired && res_valid) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign busy = (r_count != '0);

  // drain_done pulses in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= w_drain_fin;
    end
  end

  assign drain_done = r_drain_done;

`ifdef MULT_SHARE_ARBITER_STATS_EN
  logic [15:0] r_stat_grants [NUM_REQ];
  logic [15:0] r_stat_idle;

  // Saturating per-requester grant counts and idle-RUN cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_stat_grants[i] <= '0;
      end
      r_stat_idle <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && r_stat_grants[i] != 16'hFFFF) begin
          r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
        end
      end
      if (r_state == RUN && !w_fired && r_stat_idle != 16'hFFFF) begin
        r_stat_idle <= r_stat_idle + 16'd1;
      end
    end
  end

  // Flatten grant counters onto the output bus.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*16 +: 16] = r_stat_grants[i];
    end
  end

  assign stat_idle = r_stat_idle;
`endif

endmodule
